// File: rtl/bcd_tick_counter_if.sv
// ============================================================================
// Module      : bcd_tick_counter_if
// Description : Control, slow-clock input and BCD count bundle for bcd_tick_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_tick_counter_if #(
    parameter int NDIGITS = 4
);
    logic                   slow_clk;
    logic                   start;
    logic                   stop;
    logic                   clear;
    logic                   dir;
    logic [4*NDIGITS-1:0]   digits;
    logic                   tick;
    logic                   wrap;
    logic                   running;

    modport master (
        output slow_clk, start, stop, clear, dir,
        input  digits, tick, wrap, running
    );

    modport slave (
        input  slow_clk, start, stop, clear, dir,
        output digits, tick, wrap, running
    );
endinterface

`default_nettype wire

// File: rtl/bcd_tick_counter.sv
// ============================================================================
// Module      : bcd_tick_counter
// Description : Slow-clock edge to tick converter driving an up/down BCD counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_tick_counter #(
    parameter int NDIGITS = 4
) (
    input  wire logic            clk,
    input  wire logic            reset,
    bcd_tick_counter_if.slave    bus
);
    localparam logic [0:0] c_STOPPED = 1'b0;
    localparam logic [0:0] c_RUNNING = 1'b1;

    logic                   r_s1;
    logic                   r_s2;
    logic                   r_s3;
    logic [0:0]             r_state;
    logic [4*NDIGITS-1:0]   r_digits;
    logic                   r_tick;
    logic                   r_wrap;

    logic                   w_edge;
    logic                   w_adv;
    logic [0:0]             w_state_nxt;
    logic [NDIGITS:0]       w_carry;
    logic [4*NDIGITS-1:0]   w_digits_nxt;

    assign w_edge = r_s2 & ~r_s3;
    // State is sampled before this edge's transition, so start+edge never counts.
    assign w_adv  = w_edge & (r_state == c_RUNNING) & ~bus.clear;

    // Carry (up) or borrow (down) ripples from digit 0; the final carry is rollover.
    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        logic [3:0] w_d;
        logic       w_at_limit;

        assign w_d        = r_digits[4*i +: 4];
        assign w_at_limit = bus.dir ? (w_d == 4'd0) : (w_d == 4'd9);
        assign w_carry[i+1] = w_carry[i] & w_at_limit;

        always_comb begin
            w_digits_nxt[4*i +: 4] = w_d;
            if (w_carry[i]) begin
                if (bus.dir) begin
                    w_digits_nxt[4*i +: 4] = w_at_limit ? 4'd9 : (w_d - 4'd1);
                end else begin
                    w_digits_nxt[4*i +: 4] = w_at_limit ? 4'd0 : (w_d + 4'd1);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.stop) begin
            w_state_nxt = c_STOPPED;
        end else if (bus.start) begin
            w_state_nxt = c_RUNNING;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_state  <= c_STOPPED;
            r_digits <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_s1    <= bus.slow_clk;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_state <= w_state_nxt;
            r_tick  <= w_edge;
            r_wrap  <= w_adv & w_carry[NDIGITS];
            if (bus.clear) begin
                r_digits <= '0;
            end else if (w_adv) begin
                r_digits <= w_digits_nxt;
            end
        end
    end

    assign bus.digits  = r_digits;
    assign bus.tick    = r_tick;
    assign bus.wrap    = r_wrap;
    assign bus.running = (r_state == c_RUNNING);

endmodule

`default_nettype wire

// File: tb/tb_bcd_tick_counter.sv
// ============================================================================
// Module      : tb_bcd_tick_counter
// Description : Directed-vector self-checking bench for bcd_tick_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_tick_counter;
    localparam int NDIGITS = 4;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   n_ticks;

    bcd_tick_counter_if #(.NDIGITS(NDIGITS)) bus ();

    bcd_tick_counter #(.NDIGITS(NDIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise slow_clk and return just after edge N+2; c/s are asserted for that edge.
    task automatic rise(input logic c, input logic s);
        bus.slow_clk = 1'b1;
        step();
        step();
        bus.clear = c;
        bus.stop  = s;
        step();
        bus.clear = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic fall();
        bus.slow_clk = 1'b0;
        repeat (3) step();
    endtask

    task automatic count(input int n);
        for (int k = 0; k < n; k++) begin
            rise(1'b0, 1'b0);
            fall();
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_ticks = 0;
        reset = 1'b1;
        bus.slow_clk = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
        bus.dir   = 1'b0;

        // Reset held while slow_clk toggles
        step();
        for (int k = 0; k < 2; k++) begin
            bus.slow_clk = ~bus.slow_clk;
            step();
            check_eq("rst_tick", 32'(bus.tick), 32'd0);
            check_eq("rst_wrap", 32'(bus.wrap), 32'd0);
        end
        check_eq("rst_digits", 32'(bus.digits), 32'h0000);
        check_eq("rst_running", 32'(bus.running), 32'd0);
        bus.slow_clk = 1'b0;
        step();
        reset = 1'b0;
        repeat (4) step();

        pulse_start();
        check_eq("start_running", 32'(bus.running), 32'd1);

        // Latency of the first counted edge
        bus.slow_clk = 1'b1;
        step();
        check_eq("lat_n_tick", 32'(bus.tick), 32'd0);
        step();
        check_eq("lat_n1_tick", 32'(bus.tick), 32'd0);
        check_eq("lat_n1_digits", 32'(bus.digits), 32'h0000);
        step();
        check_eq("lat_n2_tick", 32'(bus.tick), 32'd1);
        check_eq("lat_n2_digits", 32'(bus.digits), 32'h0001);
        step();
        check_eq("lat_n3_tick", 32'(bus.tick), 32'd0);
        bus.slow_clk = 1'b0;
        repeat (3) step();
        check_eq("fall_no_tick", 32'(bus.tick), 32'd0);

        // Up ripple
        count(8);
        check_eq("up_0009", 32'(bus.digits), 32'h0009);
        count(1);
        check_eq("up_0010", 32'(bus.digits), 32'h0010);
        count(989);
        check_eq("up_0999", 32'(bus.digits), 32'h0999);
        rise(1'b0, 1'b0);
        check_eq("up_1000", 32'(bus.digits), 32'h1000);
        check_eq("up_1000_wrap", 32'(bus.wrap), 32'd0);
        fall();

        // Down count
        bus.dir = 1'b1;
        rise(1'b0, 1'b0);
        check_eq("dn_0999", 32'(bus.digits), 32'h0999);
        fall();
        pulse_clear();
        check_eq("clear_idle", 32'(bus.digits), 32'h0000);
        rise(1'b0, 1'b0);
        check_eq("dn_9999", 32'(bus.digits), 32'h9999);
        check_eq("dn_wrap", 32'(bus.wrap), 32'd1);
        step();
        check_eq("dn_wrap_1cyc", 32'(bus.wrap), 32'd0);
        bus.slow_clk = 1'b0;
        repeat (3) step();

        bus.dir = 1'b0;
        rise(1'b0, 1'b0);
        check_eq("up_0000", 32'(bus.digits), 32'h0000);
        check_eq("up_wrap", 32'(bus.wrap), 32'd1);
        step();
        check_eq("up_wrap_1cyc", 32'(bus.wrap), 32'd0);
        bus.slow_clk = 1'b0;
        repeat (3) step();

        // Clear coincident with an edge
        count(42);
        check_eq("pre_0042", 32'(bus.digits), 32'h0042);
        rise(1'b1, 1'b0);
        check_eq("clr_edge_digits", 32'(bus.digits), 32'h0000);
        check_eq("clr_edge_tick", 32'(bus.tick), 32'd1);
        check_eq("clr_edge_wrap", 32'(bus.wrap), 32'd0);
        fall();

        // Start with edge in the same cycle does not count
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        rise(1'b0, 1'b0);
        fall();
        bus.slow_clk = 1'b1;
        step();
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq("start_edge_digits", 32'(bus.digits), 32'h0000);
        check_eq("start_edge_running", 32'(bus.running), 32'd1);
        fall();

        // Stop coincident with an edge still counts
        count(5);
        check_eq("pre_0005", 32'(bus.digits), 32'h0005);
        rise(1'b0, 1'b1);
        check_eq("stop_edge_digits", 32'(bus.digits), 32'h0006);
        check_eq("stop_edge_running", 32'(bus.running), 32'd0);
        fall();

        // Edges while STOPPED tick but do not count
        for (int k = 0; k < 5; k++) begin
            rise(1'b0, 1'b0);
            if (bus.tick === 1'b1) n_ticks++;
            fall();
        end
        check_eq("stopped_ticks", 32'(n_ticks), 32'd5);
        check_eq("stopped_digits", 32'(bus.digits), 32'h0006);

        // start+stop together: stop wins from RUNNING
        pulse_start();
        check_eq("restart_running", 32'(bus.running), 32'd1);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_eq("start_stop_running", 32'(bus.running), 32'd0);

        // Reset mid-count
        pulse_start();
        pulse_clear();
        count(123);
        check_eq("pre_0123", 32'(bus.digits), 32'h0123);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midrst_digits", 32'(bus.digits), 32'h0000);
        check_eq("midrst_running", 32'(bus.running), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
